// File: rtl/matrix_load_controller.sv
// Matrix load controller: turns a received dibit stream into a header byte N
// followed by two N x N row-major byte matrices (A then B). It writes them to
// matrix memory and launches the compute engine once a complete frame ends.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a fresh frame (axiiv rising edge)
// HDR     | assembling the header byte N
// LOAD_A  | writing N*N bytes of matrix A
// LOAD_B  | writing N*N bytes of matrix B
// DRAIN   | discarding the rest of the frame until axiiv drops
// START   | one-cycle compute_start pulse
// RUN     | waiting for compute_done; receive stream ignored
module matrix_load_controller #(
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  input  logic              compute_done,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [3:0]        dim,
  output logic              compute_start,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_DRAIN, S_START, S_RUN
  } state_t;

  localparam logic [7:0] MAX_N_B = 8'(MAX_N);

  state_t            r_state, w_state_nxt;
  logic              r_axiiv_d;
  logic [1:0]        r_dcnt;
  logic [5:0]        r_shift;
  logic [7:0]        r_cnt;
  logic              r_ok;
  logic              r_wr_en, r_wr_sel, r_frame_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [3:0]        r_dim;

  logic              w_byte_vld;
  logic [7:0]        w_byte;
  logic [7:0]        w_nn;
  logic              w_last;
  logic              w_hdr_ok;
  logic              w_wr;
  logic              w_err;

  assign w_byte_vld = axiiv && (r_dcnt == 2'd3);
  assign w_byte     = {axiid, r_shift};
  assign w_nn       = {4'd0, r_dim} * {4'd0, r_dim};
  assign w_last     = (r_cnt == (w_nn - 8'd1));
  assign w_hdr_ok   = (w_byte != 8'd0) && (w_byte <= MAX_N_B);

  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign dim       = r_dim;
  assign frame_err = r_frame_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (axiiv && !r_axiiv_d) w_state_nxt = S_HDR;
      S_HDR: begin
        if (!axiiv)          w_state_nxt = S_IDLE;
        else if (w_byte_vld) w_state_nxt = w_hdr_ok ? S_LOAD_A : S_DRAIN;
      end
      S_LOAD_A: begin
        if (!axiiv)                    w_state_nxt = S_IDLE;
        else if (w_byte_vld && w_last) w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (!axiiv)                    w_state_nxt = S_IDLE;
        else if (w_byte_vld && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (!axiiv) w_state_nxt = r_ok ? S_START : S_IDLE;
      S_START:  w_state_nxt = S_RUN;
      S_RUN:    if (compute_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs plus write/error requests for the registered stage.
  always_comb begin
    w_wr          = 1'b0;
    w_err         = 1'b0;
    busy          = (r_state != S_IDLE);
    compute_start = (r_state == S_START);
    case (r_state)
      S_HDR:              w_err = !axiiv || (w_byte_vld && !w_hdr_ok);
      S_LOAD_A, S_LOAD_B: begin
        w_wr  = w_byte_vld;
        w_err = !axiiv;
      end
      default: ;
    endcase
  end

  // Dibit assembly; the counter runs in every state so byte framing is
  // always aligned to the start of axiiv.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Held high so a frame already running at reset release is not
      // mistaken for a new one.
      r_axiiv_d <= 1'b1;
      r_dcnt    <= 2'd0;
      r_shift   <= 6'd0;
    end else begin
      r_axiiv_d <= axiiv;
      if (!axiiv) begin
        r_dcnt <= 2'd0;
      end else begin
        r_dcnt <= r_dcnt + 2'd1;
        case (r_dcnt)
          2'd0:    r_shift[1:0] <= axiid;
          2'd1:    r_shift[3:2] <= axiid;
          2'd2:    r_shift[5:4] <= axiid;
          default: ;
        endcase
      end
    end
  end

  // Write port, element counter, header latch, success flag and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en     <= 1'b0;
      r_wr_sel    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_frame_err <= 1'b0;
      r_dim       <= 4'd0;
      r_cnt       <= 8'd0;
      r_ok        <= 1'b0;
    end else begin
      r_wr_en     <= w_wr;
      r_frame_err <= w_err;
      if (r_state == S_HDR && w_byte_vld && w_hdr_ok) r_dim <= w_byte[3:0];
      if (w_wr) begin
        r_wr_sel  <= (r_state == S_LOAD_B);
        r_wr_addr <= ADDR_W'(r_cnt);
        r_wr_data <= w_byte;
        r_cnt     <= w_last ? 8'd0 : r_cnt + 8'd1;
      end else if (r_state != S_LOAD_A && r_state != S_LOAD_B) begin
        r_cnt <= 8'd0;
      end
      if (r_state == S_LOAD_B && w_wr && w_last)            r_ok <= 1'b1;
      else if (r_state == S_IDLE || r_state == S_START)     r_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_load_controller.sv
// Directed bench for matrix_load_controller with a write scoreboard.
module tb_matrix_load_controller;
  localparam int MAX_N  = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              axiiv = 1'b0;
  logic [1:0]        axiid = 2'd0;
  logic              compute_done = 1'b0;
  logic              wr_en, wr_sel, compute_start, busy, frame_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        dim;

  matrix_load_controller #(.MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .compute_done(compute_done), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .dim(dim),
    .compute_start(compute_start), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop-and-compare every write; count pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) err_cnt++;
      if (compute_start) start_cnt++;
      if (wr_en) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_errors++;
          $error("FAIL wr_unexpected: observed sel=%0d addr=%0d data=%0h expected no write",
                 wr_sel, wr_addr, wr_data);
        end
        if (exp_q.size() != 0)
          check("wr_beat", {17'd0, wr_sel, wr_addr, wr_data}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d);
    axiiv = 1'b1;
    axiid = d;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    axiid = 2'd0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_wr(input logic sel, input logic [5:0] addr, input logic [7:0] data);
    exp_q.push_back({sel, addr, data});
  endtask

  task automatic pulse_done();
    compute_done = 1'b1;
    @(posedge clk); #1;
    compute_done = 1'b0;
  endtask

  // Header n, then 2*n*n bytes seed, seed+1, ...; optionally scoreboarded.
  task automatic load_frame(input int n, input logic [7:0] seed, input bit exp_wr);
    send_byte(n[7:0]);
    for (int i = 0; i < 2*n*n; i++) begin
      logic [7:0] d;
      d = seed + 8'(i);
      if (exp_wr) expect_wr(i >= n*n, 6'(i % (n*n)), d);
      send_byte(d);
    end
  endtask

  initial begin
    int e0, s0;
    logic [7:0] bad_hdr [2];
    bad_hdr[0] = 8'h00;
    bad_hdr[1] = 8'h09;

    // Reset state
    #23;
    check("reset_outputs", {9'd0, wr_en, wr_sel, wr_addr, wr_data, dim, compute_start, busy, frame_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Basic N=2 frame
    e0 = err_cnt; s0 = start_cnt;
    load_frame(2, 8'h01, 1'b1);
    check("t1_dim", dim, 2);
    check("t1_busy_drain", busy, 1);
    check("t1_no_start_before_low", start_cnt, s0);
    idle(4);
    check("t1_start_once", start_cnt, s0 + 1);
    idle(6);
    check("t1_busy_run", busy, 1);
    pulse_done();
    @(negedge clk);
    check("t1_busy_idle", busy, 0);
    check("t1_no_err", err_cnt, e0);
    check("t1_sb_empty", exp_q.size(), 0);
    idle(2);

    // Dibit order: 11,10,01,00 -> 0x1B
    s0 = start_cnt;
    send_byte(8'h01);
    expect_wr(1'b0, 6'd0, 8'h1B);
    send_dibit(2'b11); send_dibit(2'b10); send_dibit(2'b01); send_dibit(2'b00);
    expect_wr(1'b1, 6'd0, 8'hA5);
    send_byte(8'hA5);
    idle(4);
    check("t2_start", start_cnt, s0 + 1);
    check("t2_dim", dim, 1);
    pulse_done();
    idle(2);
    check("t2_idle", busy, 0);

    // Rejected headers 00 and 09
    for (int k = 0; k < 2; k++) begin
      e0 = err_cnt; s0 = start_cnt;
      send_byte(bad_hdr[k]);
      send_byte(8'h11);
      send_byte(8'h22);
      check("t3_busy_drain", busy, 1);
      idle(4);
      check("t3_err", err_cnt, e0 + 1);
      check("t3_no_start", start_cnt, s0);
      check("t3_idle", busy, 0);
      check("t3_dim_kept", dim, 1);
    end

    // N = MAX_N boundary: addresses 0..63 in both matrices
    s0 = start_cnt;
    load_frame(MAX_N, 8'h40, 1'b1);
    check("t4_dim", dim, MAX_N);
    idle(4);
    check("t4_start", start_cnt, s0 + 1);
    pulse_done();
    idle(2);
    check("t4_sb_empty", exp_q.size(), 0);

    // Truncated N=2 frame after 5 data bytes plus a partial byte
    e0 = err_cnt; s0 = start_cnt;
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) begin
      expect_wr(i >= 4, 6'(i % 4), 8'h50 + 8'(i));
      send_byte(8'h50 + 8'(i));
    end
    send_dibit(2'd1); send_dibit(2'd2);
    idle(4);
    check("t5_err", err_cnt, e0 + 1);
    check("t5_no_start", start_cnt, s0);
    check("t5_idle", busy, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // Frames during RUN are ignored; compute_done mid-frame
    s0 = start_cnt;
    load_frame(1, 8'h11, 1'b1);
    idle(4);
    check("t6_start", start_cnt, s0 + 1);
    e0 = err_cnt; s0 = start_cnt;
    load_frame(2, 8'h70, 1'b0);
    idle(4);
    check("t6_run_no_start", start_cnt, s0);
    check("t6_run_busy", busy, 1);
    check("t6_run_dim", dim, 1);
    send_byte(8'h01);
    send_byte(8'h33);
    compute_done = 1'b1;
    send_dibit(2'd0);
    compute_done = 1'b0;
    send_dibit(2'd1); send_dibit(2'd2); send_dibit(2'd3);
    send_byte(8'h44);
    check("t6_idle_midframe", busy, 0);
    idle(4);
    check("t6_no_err", err_cnt, e0);
    check("t6_no_start", start_cnt, s0);
    pulse_done();
    check("t6_done_in_idle", busy, 0);
    load_frame(2, 8'h80, 1'b1);
    check("t6_next_dim", dim, 2);
    idle(4);
    check("t6_next_start", start_cnt, s0 + 1);
    pulse_done();
    idle(2);

    // Async reset during LOAD_B; tail ignored
    e0 = err_cnt; s0 = start_cnt;
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) begin
      expect_wr(i >= 4, 6'(i % 4), 8'h90 + 8'(i));
      send_byte(8'h90 + 8'(i));
    end
    send_dibit(2'd1);
    check("t7_busy_pre_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_async", {9'd0, wr_en, wr_sel, wr_addr, wr_data, dim, compute_start, busy, frame_err}, 32'd0);
    send_dibit(2'd2); send_dibit(2'd3);
    rst = 1'b1;
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    check("t7_tail_ignored", busy, 0);
    idle(4);
    check("t7_no_err", err_cnt, e0);
    check("t7_no_start", start_cnt, s0);

    // Normal frame with trailing bytes after B
    load_frame(2, 8'hC0, 1'b1);
    send_byte(8'hEE); send_byte(8'hEF); send_byte(8'hF0);
    check("t8_busy_drain", busy, 1);
    check("t8_no_early_start", start_cnt, s0);
    idle(4);
    check("t8_start", start_cnt, s0 + 1);
    check("t8_dim", dim, 2);
    pulse_done();
    idle(2);
    check("t8_idle", busy, 0);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_no_err", err_cnt, e0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
